miller_mod_encoder: RTL and testbench

- Modified Miller transmitter for the ISO 14443A reader-to-card link at 106 kb/s.
- Mirror of the receive-side SoF/Miller decode chain: serialises bytes into a frame of SoF, data, optional odd parity and EoF.
- Drives a pause (100% ASK) modulator line.
- Runs on the fc/4 clock (3.39 MHz), so one ETU is 32 clocks.

---
 rtl/miller_pkg.sv | 41 ++++
 rtl/miller_symbol_gen.sv | 44 ++++
 rtl/miller_mod_encoder.sv | 192 +++++++++++++++++++
 tb/tb_miller_mod_encoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/miller_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | miller_pkg                                                          |
// | Modified Miller symbol and state definitions for ISO 14443A 106k.   |
// | Shared by the transmit encoder and the receive-side detectors.      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package miller_pkg;

    localparam int ETU_CLKS_106  = 32;
    localparam int PAUSE_LEN_106 = 8;

    typedef enum logic [1:0] {
        SYM_X = 2'd0,
        SYM_Y = 2'd1,
        SYM_Z = 2'd2
    } sym_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_SOF  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_PAR  = 3'd3;
    localparam state_t ST_EOF0 = 3'd4;
    localparam state_t ST_EOFY = 3'd5;

    // A 1 is always X; a 0 is Z after a 0 (or SoF) and Y after a 1.
    function automatic sym_e bit_to_sym(input logic b, input logic prev_bit);
        if (b) begin
            return SYM_X;
        end else if (prev_bit) begin
            return SYM_Y;
        end else begin
            return SYM_Z;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/miller_symbol_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | miller_symbol_gen                                                   |
// | Turns a symbol type and ETU clock index into the registered pause.  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module miller_symbol_gen
    import miller_pkg::*;
#(
    parameter int ETU_CLKS  = ETU_CLKS_106,
    parameter int PAUSE_LEN = PAUSE_LEN_106,
    parameter int K_W       = $clog2(ETU_CLKS)
) (
    input  logic           clk,
    input  logic           rst,
    input  sym_e           i_sym,
    input  logic [K_W-1:0] i_k,
    output logic           o_pause
);

    localparam logic [K_W-1:0] c_z_end   = K_W'(PAUSE_LEN);
    localparam logic [K_W-1:0] c_x_start = K_W'(ETU_CLKS / 2);
    localparam logic [K_W-1:0] c_x_end   = K_W'(ETU_CLKS / 2 + PAUSE_LEN);

    logic w_in_z;
    logic w_in_x;
    logic r_pause;

    assign w_in_z = (i_sym == SYM_Z) && (i_k < c_z_end);
    assign w_in_x = (i_sym == SYM_X) && (i_k >= c_x_start) && (i_k < c_x_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pause <= 1'b0;
        end else begin
            r_pause <= w_in_z | w_in_x;
        end
    end

    assign o_pause = r_pause;

endmodule
`default_nettype wire

// File: rtl/miller_mod_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | miller_mod_encoder                                                  |
// | ISO 14443A 106 kb/s reader-to-card Modified Miller transmitter:     |
// | SoF, LSB-first data, optional odd parity, EoF on a pause line.      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module miller_mod_encoder
    import miller_pkg::*;
#(
    parameter int ETU_CLKS  = ETU_CLKS_106,
    parameter int PAUSE_LEN = PAUSE_LEN_106,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    input  logic [2:0] in_nbits,
    output logic       out_ready,
    output logic       out_pause,
    output logic       out_busy,
    output logic       out_done,
    output logic       out_underrun
);

    localparam int             c_k_w    = $clog2(ETU_CLKS);
    localparam logic [c_k_w-1:0] c_k_last = c_k_w'(ETU_CLKS - 1);

    state_t           r_state,   w_state_nxt;
    logic [c_k_w-1:0] r_k,       w_k_nxt;
    logic [2:0]       r_bit,     w_bit_nxt;
    logic [2:0]       r_end_bit, w_end_bit_nxt;
    logic [7:0]       r_shift,   w_shift_nxt;
    logic             r_last,    w_last_nxt;
    logic             r_par,     w_par_nxt;
    logic             r_prev,    w_prev_nxt;
    logic             r_under,   w_under_nxt;
    logic             r_done,    w_done_nxt;
    logic             r_underrun_p;

    logic             w_etu_end;
    logic             w_full;
    logic             w_last_bit;
    logic             w_boundary;
    logic             w_accept;
    sym_e             w_sym_nxt;

    assign w_etu_end  = (r_k == c_k_last);
    assign w_full     = (r_end_bit == 3'd7);
    assign w_last_bit = (r_bit == r_end_bit);

    // Final symbol of a byte: the parity ETU, or the last data bit when no parity follows.
    assign w_boundary = (r_state == ST_PAR) ||
                        ((r_state == ST_DATA) && w_last_bit && !(PARITY_EN && w_full));

    assign out_ready = (r_state == ST_IDLE) || (w_boundary && w_etu_end && !r_last);
    assign w_accept  = in_valid && out_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_bit_nxt     = r_bit;
        w_end_bit_nxt = r_end_bit;
        w_shift_nxt   = r_shift;
        w_last_nxt    = r_last;
        w_par_nxt     = r_par;
        w_prev_nxt    = r_prev;
        w_under_nxt   = r_under;
        w_done_nxt    = 1'b0;

        if (r_state == ST_IDLE) begin
            w_k_nxt = '0;
            if (w_accept) begin
                w_state_nxt = ST_SOF;
                w_under_nxt = 1'b0;
            end
        end else begin
            w_k_nxt = w_etu_end ? '0 : r_k + c_k_w'(1);
            if (w_etu_end) begin
                case (r_state)
                    ST_SOF: begin
                        w_prev_nxt  = 1'b0;
                        w_state_nxt = ST_DATA;
                    end
                    ST_DATA: begin
                        w_prev_nxt = r_shift[0];
                        if (!w_last_bit) begin
                            w_shift_nxt = {1'b0, r_shift[7:1]};
                            w_bit_nxt   = r_bit + 3'd1;
                        end else if (PARITY_EN && w_full) begin
                            w_state_nxt = ST_PAR;
                        end else if (w_accept) begin
                            w_state_nxt = ST_DATA;
                        end else begin
                            w_state_nxt = ST_EOF0;
                            w_under_nxt = !r_last;
                        end
                    end
                    ST_PAR: begin
                        w_prev_nxt = r_par;
                        if (w_accept) begin
                            w_state_nxt = ST_DATA;
                        end else begin
                            w_state_nxt = ST_EOF0;
                            w_under_nxt = !r_last;
                        end
                    end
                    ST_EOF0: begin
                        w_state_nxt = ST_EOFY;
                    end
                    ST_EOFY: begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end

        // A byte loads identically whether it opens a frame or chains at a boundary.
        if (w_accept) begin
            w_shift_nxt   = in_data;
            w_last_nxt    = in_last;
            w_end_bit_nxt = in_last ? (in_nbits - 3'd1) : 3'd7;
            w_par_nxt     = ~^in_data;
            w_bit_nxt     = '0;
        end
    end

    // The symbol generator registers pause from next-cycle values so it lines up with state.
    always_comb begin
        w_sym_nxt = SYM_Y;
        case (w_state_nxt)
            ST_SOF:  w_sym_nxt = SYM_Z;
            ST_DATA: w_sym_nxt = bit_to_sym(w_shift_nxt[0], w_prev_nxt);
            ST_PAR:  w_sym_nxt = bit_to_sym(w_par_nxt, w_prev_nxt);
            ST_EOF0: w_sym_nxt = bit_to_sym(1'b0, w_prev_nxt);
            default: w_sym_nxt = SYM_Y;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state      <= ST_IDLE;
            r_k          <= '0;
            r_bit        <= '0;
            r_end_bit    <= '0;
            r_shift      <= '0;
            r_last       <= 1'b0;
            r_par        <= 1'b0;
            r_prev       <= 1'b0;
            r_under      <= 1'b0;
            r_done       <= 1'b0;
            r_underrun_p <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_k          <= w_k_nxt;
            r_bit        <= w_bit_nxt;
            r_end_bit    <= w_end_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_last       <= w_last_nxt;
            r_par        <= w_par_nxt;
            r_prev       <= w_prev_nxt;
            r_under      <= w_under_nxt;
            r_done       <= w_done_nxt;
            r_underrun_p <= w_done_nxt & r_under;
        end
    end

    miller_symbol_gen #(
        .ETU_CLKS  (ETU_CLKS),
        .PAUSE_LEN (PAUSE_LEN),
        .K_W       (c_k_w)
    ) u_symbol_gen (
        .clk     (in_clk),
        .rst     (in_rst),
        .i_sym   (w_sym_nxt),
        .i_k     (w_k_nxt),
        .o_pause (out_pause)
    );

    assign out_busy     = (r_state != ST_IDLE);
    assign out_done     = r_done;
    assign out_underrun = r_underrun_p;

endmodule
`default_nettype wire

// File: tb/tb_miller_mod_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_miller_mod_encoder                                               |
// | Frame-level symbol model of the Modified Miller transmitter.        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_miller_mod_encoder;

    localparam int  ETU = 32;
    localparam int  PL  = 8;
    localparam byte SX  = 8'h58;
    localparam byte SY  = 8'h59;
    localparam byte SZ  = 8'h5A;

    logic       in_clk   = 1'b0;
    logic       in_rst   = 1'b1;
    logic [7:0] in_data  = '0;
    logic       in_valid = 1'b0;
    logic       in_last  = 1'b0;
    logic [2:0] in_nbits = '0;
    logic       out_ready, out_pause, out_busy, out_done, out_underrun;

    miller_mod_encoder #(
        .ETU_CLKS  (ETU),
        .PAUSE_LEN (PL),
        .PARITY_EN (1'b1)
    ) dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_nbits     (in_nbits),
        .out_ready    (out_ready),
        .out_pause    (out_pause),
        .out_busy     (out_busy),
        .out_done     (out_done),
        .out_underrun (out_underrun)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic pause;
        logic busy;
        logic ready;
        logic done;
        logic und;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cmp_e;
    int         n_pass  = 0;
    int         n_total = 0;
    bit         chk_en  = 1'b0;
    logic [7:0] fb[4];
    byte        m_sym[$];
    int         m_nxt[$];   // per ETU: -1, or index of byte offered at its end (n = none, starve)

    function automatic exp_t mk(input logic p, input logic b, input logic r, input logic d, input logic u);
        exp_t e;
        e.pause = p; e.busy = b; e.ready = r; e.done = d; e.und = u;
        return e;
    endfunction

    task automatic chk_bit(input string name, input logic got, input logic want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
    endtask

    task automatic chk_str(input string name, input string got, input string want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%s want=%s", name, got, want);
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", name, got, want);
    endtask

    // Symbol list of a whole frame from the encoding rules.
    function automatic void build_model(input int n, input logic [2:0] nb, input bit starve);
        bit prev;
        m_sym.delete();
        m_nxt.delete();
        m_sym.push_back(SZ);
        m_nxt.push_back(-1);
        prev = 1'b0;
        for (int j = 0; j < n; j++) begin
            int cnt;
            cnt = (j == n - 1 && !starve && nb != 3'd0) ? int'(nb) : 8;
            for (int i = 0; i < cnt + ((cnt == 8) ? 1 : 0); i++) begin
                bit b;
                if (i < cnt) b = fb[j][i];
                else b = ($countones(fb[j]) % 2 == 0);
                if (b) m_sym.push_back(SX);
                else if (prev) m_sym.push_back(SY);
                else m_sym.push_back(SZ);
                m_nxt.push_back(-1);
                prev = b;
            end
            m_nxt[m_nxt.size() - 1] = (j < n - 1) ? j + 1 : (starve ? n : -1);
        end
        m_sym.push_back(prev ? SY : SZ);
        m_nxt.push_back(-1);
        m_sym.push_back(SY);
        m_nxt.push_back(-1);
    endfunction

    function automatic string model_str();
        string s;
        s = "";
        foreach (m_sym[i]) s = $sformatf("%s%c", s, m_sym[i]);
        return s;
    endfunction

    function automatic int first_rdy_etu();
        foreach (m_nxt[i]) if (m_nxt[i] != -1) return i;
        return -1;
    endfunction

    function automatic exp_t exp_at(input int c);
        int  k;
        byte s;
        k = c % ETU;
        s = m_sym[c / ETU];
        return mk((s == SZ && k < PL) || (s == SX && k >= ETU / 2 && k < ETU / 2 + PL),
                  1'b1, (k == ETU - 1) && (m_nxt[c / ETU] != -1), 1'b0, 1'b0);
    endfunction

    always @(negedge in_clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) cmp_e = exp_q.pop_front();
            else cmp_e = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk_bit("pause", out_pause, cmp_e.pause);
            chk_bit("busy", out_busy, cmp_e.busy);
            chk_bit("ready", out_ready, cmp_e.ready);
            chk_bit("done", out_done, cmp_e.done);
            chk_bit("underrun", out_underrun, cmp_e.und);
        end
    end

    task automatic drive(input logic [7:0] d, input logic last, input logic [2:0] nb);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_nbits = last ? nb : 3'($urandom);
    endtask

    task automatic noise();
        in_valid = ($urandom_range(0, 3) == 0);
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        in_nbits = 3'($urandom);
    endtask

    // Returns at the start of the done cycle, so a b2b frame can be offered right there.
    task automatic run_frame(input int n, input logic [2:0] nb, input bit starve, input bit b2b);
        int len;
        build_model(n, nb, starve);
        len = m_sym.size() * ETU;
        if (!b2b) begin
            @(posedge in_clk); #1;
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        drive(fb[0], (n == 1) && !starve, nb);
        @(posedge in_clk); #1;
        for (int c = 0; c < len; c++) begin
            int e;
            e = c / ETU;
            exp_q.push_back(exp_at(c));
            if (c % ETU == ETU - 1 && m_nxt[e] != -1) begin
                if (m_nxt[e] < n) drive(fb[m_nxt[e]], (m_nxt[e] == n - 1) && !starve, nb);
                else in_valid = 1'b0;
            end else begin
                noise();
            end
            @(posedge in_clk); #1;
        end
        in_valid = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, starve));
    endtask

    task automatic run_reset();
        int rc;
        rc = 5 * ETU + 3;
        fb[0] = 8'h26;
        build_model(1, 3'd7, 1'b0);
        chk_bit("rst_model_pause", exp_at(rc).pause, 1'b1);
        @(posedge in_clk); #1;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        drive(fb[0], 1'b1, 3'd7);
        @(posedge in_clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < rc; c++) begin
            exp_q.push_back(exp_at(c));
            @(posedge in_clk); #1;
        end
        exp_q.push_back(exp_at(rc));
        in_rst = 1'b1;
        @(posedge in_clk); #1;
        in_rst = 1'b0;
        chk_bit("rst_mid_pause", out_pause, 1'b0);
        chk_bit("rst_mid_busy", out_busy, 1'b0);
        chk_bit("rst_mid_ready", out_ready, 1'b1);
        repeat (40) @(posedge in_clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        @(posedge in_clk); #1;
        chk_en = 1'b1;
        repeat (3) @(posedge in_clk);
        #1;
        in_rst = 1'b0;
        chk_bit("reset_ready", out_ready, 1'b1);
        chk_bit("reset_busy", out_busy, 1'b0);
        chk_bit("reset_pause", out_pause, 1'b0);
        chk_bit("reset_done", out_done, 1'b0);

        fb[0] = 8'h26;
        build_model(1, 3'd7, 1'b0);
        chk_str("reqa_model", model_str(), "ZZXXYZXYZY");
        run_frame(1, 3'd7, 1'b0, 1'b0);

        fb[0] = 8'h93; fb[1] = 8'h20;
        build_model(2, 3'd0, 1'b0);
        chk_str("anticoll_model", model_str(), "ZXXYZXYZXXYZZZZXYZZZY");
        chk_int("anticoll_rdy_etu", first_rdy_etu(), 9);
        run_frame(2, 3'd0, 1'b0, 1'b0);

        fb[0] = 8'hA5;
        build_model(1, 3'd0, 1'b1);
        chk_int("underrun_len", m_sym.size(), 12);
        run_frame(1, 3'd0, 1'b1, 1'b0);

        run_reset();
        fb[0] = 8'h26;
        run_frame(1, 3'd7, 1'b0, 1'b0);

        fb[0] = 8'h52;
        run_frame(1, 3'd7, 1'b0, 1'b0);
        run_frame(1, 3'd7, 1'b0, 1'b1);

        for (int f = 0; f < 14; f++) begin
            int         n;
            logic [2:0] nb;
            bit         st;
            bit         bb;
            n  = $urandom_range(1, 3);
            for (int j = 0; j < 4; j++) fb[j] = 8'($urandom);
            nb = 3'($urandom);
            st = ($urandom_range(0, 3) == 0);
            bb = (f > 0) && ($urandom_range(0, 1) == 1);
            run_frame(n, nb, st, bb);
        end

        repeat (5) @(posedge in_clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
